// File: rtl/debug_ocimem_arbiter.sv
// Arbiter for the Nios II on-chip debug memory (OCI RAM).
// It shares the single RAM port between the JTAG debug slave and the CPU Avalon slave.
// When both request in the same idle cycle, the grant alternates round-robin.
module debug_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic [37:0]         jdo,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
  input  logic [3:0]          avs_byteenable,
  output logic                avs_waitrequest,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [3:0]          ram_byteen,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                jtag_busy,
  output logic                jtag_overrun
);

  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_JTAG = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t              state;
  logic                last_grant;
  logic                cur_jtag;    // the access in flight belongs to JTAG
  logic                cur_wr;      // the access in flight is a write
  logic [ADDR_W-1:0]   jtag_addr;
  logic                jq_wr;       // queued JTAG access is a write
  logic                jq_inc;      // queued JTAG access advances jtag_addr on completion
  logic [DATA_W-1:0]   jq_data;
  logic [DATA_W-1:0]   avs_rd_hold;
  logic                cpu_req;
  logic                grant_jtag;
  logic                unused_jdo;

  // jdo bits that carry no meaning for memory accesses
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign cpu_req = avs_read | avs_write;

  // A pending JTAG access takes the RAM unless the CPU also asks and JTAG had the last grant
  assign grant_jtag = jtag_busy & (~cpu_req | (last_grant == GRANT_CPU));

  // RAM data arrives in RDATA, so a CPU read takes it straight from the RAM in that cycle.
  // In every other cycle the value captured from the last CPU read is held.
  assign avs_readdata = (state == RDATA && !cur_jtag) ? ram_rdata : avs_rd_hold;

  // JTAG request capture, arbitration FSM and RAM port registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      last_grant      <= GRANT_CPU;
      cur_jtag        <= 1'b0;
      cur_wr          <= 1'b0;
      jtag_addr       <= '0;
      jq_wr           <= 1'b0;
      jq_inc          <= 1'b0;
      jq_data         <= '0;
      jtag_busy       <= 1'b0;
      jtag_overrun    <= 1'b0;
      MonDReg         <= '0;
      avs_rd_hold     <= '0;
      avs_waitrequest <= 1'b1;
      ram_addr        <= '0;
      ram_wr          <= 1'b0;
      ram_wdata       <= '0;
      ram_byteen      <= '0;
    end else begin
      avs_waitrequest <= 1'b1;
      ram_wr          <= 1'b0;

      // JTAG strobes are accepted only while no JTAG access is outstanding; strobe a has priority
      if (take_action_ocimem_a || take_action_ocimem_b) begin
        if (jtag_busy) begin
          jtag_overrun <= 1'b1;
        end else if (take_action_ocimem_a) begin
          jtag_addr <= jdo[ADDR_W+16:17];
          if (jdo[34]) begin
            jtag_busy <= 1'b1;
            jq_wr     <= 1'b0;
            jq_inc    <= 1'b0;
          end
        end else begin
          jtag_busy <= 1'b1;
          jq_wr     <= jdo[35];
          jq_inc    <= 1'b1;
          jq_data   <= jdo[34:3];
        end
      end

      case (state)
        IDLE: begin
          if (grant_jtag) begin
            ram_addr   <= jtag_addr;
            ram_wr     <= jq_wr;
            ram_wdata  <= jq_data;
            ram_byteen <= 4'hF;
            cur_jtag   <= 1'b1;
            cur_wr     <= jq_wr;
            last_grant <= GRANT_JTAG;
            state      <= ISSUE;
          end else if (cpu_req) begin
            ram_addr   <= avs_address;
            ram_wr     <= avs_write;
            ram_wdata  <= avs_writedata;
            ram_byteen <= avs_byteenable;
            cur_jtag   <= 1'b0;
            cur_wr     <= avs_write;
            last_grant <= GRANT_CPU;
            state      <= ISSUE;
            // A CPU write completes in ISSUE
            if (avs_write) begin
              avs_waitrequest <= 1'b0;
            end
          end
        end

        ISSUE: begin
          if (cur_wr) begin
            state <= IDLE;
            if (cur_jtag) begin
              jtag_addr <= jtag_addr + ADDR_W'(1);
              jtag_busy <= 1'b0;
            end
          end else begin
            state <= RDATA;
            // A CPU read completes in RDATA
            if (!cur_jtag) begin
              avs_waitrequest <= 1'b0;
            end
          end
        end

        RDATA: begin
          state <= IDLE;
          if (cur_jtag) begin
            MonDReg   <= ram_rdata;
            jtag_busy <= 1'b0;
            if (jq_inc) begin
              jtag_addr <= jtag_addr + ADDR_W'(1);
            end
          end else begin
            avs_rd_hold <= ram_rdata;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
